// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: ALU op codes, FSM encoding
// and the legal-op test used to flag unsupported operations.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               grant_any_o
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
    grant_any_o = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters with
// round-robin arbitration and one registered operation in flight at a time.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_op,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshakes: a request transfers on the rising edge where req_valid[i] and
  // req_ready[i] are both high; a response transfers on the edge where
  // rsp_valid[i] and rsp_ready[i] are both high. Ready never waits on valid
  // of the same channel combinationally beyond the arbitration decision.

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     res_q, res_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [3:0]  sel_op;
  logic        sel_rsp_ready;
  logic [NUM_REQ-1:0] gnt_onehot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .grant_any_o (arb_any)
  );

  // Payload of the requester the arbiter is currently pointing at.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[4*i +: 4];
      end
    end
  end

  // Only the owner's rsp_ready can retire a response.
  always_comb begin
    sel_rsp_ready = 1'b0;
    gnt_onehot    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == ID_W'(i)) begin
        sel_rsp_ready = rsp_ready[i];
        gnt_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    zero_d    = zero_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          // Gated by reset_n so every output reads 0 while reset is held.
          req_ready = arb_grant & {NUM_REQ{reset_n}};
          gnt_d     = arb_idx;
          a_d       = sel_a;
          b_d       = sel_b;
          op_d      = sel_op;
          rr_ptr_d  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        err_d   = !op_is_legal(op_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = gnt_onehot;
        if (sel_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, hand-written corner sequences
// and randomized traffic scored against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int SB_W    = 35;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*4-1:0]  req_op;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [3:0]            alu_ctrl;
  logic [31:0]           alu_result;
  logic                  alu_zero;
  logic                  busy;
  logic [1:0]            dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SB_W-1:0] exp_q[$];

  alu_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Reference ALU behaviour: {err, zero, result}.
  function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0100: r = a - b;
      4'b1000: r = (a < b) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    return {e, (r == 32'd0), r};
  endfunction

  // Stand-in for the external ALU the parent would instantiate.
  logic [33:0] alu_model;
  always_comb alu_model = ref_alu(alu_ctrl, alu_a, alu_b);
  assign alu_result = alu_model[31:0];
  assign alu_zero   = alu_model[32];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " req_ready"}, 64'(req_ready), 64'd0);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, " rsp_result"}, 64'(rsp_result), 64'd0);
    check({tag, " rsp_zero"}, 64'(rsp_zero), 64'd0);
    check({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, " alu_a"}, 64'(alu_a), 64'd0);
    check({tag, " alu_b"}, 64'(alu_b), 64'd0);
    check({tag, " alu_ctrl"}, 64'(alu_ctrl), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int p, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    req_valid[p]       = 1'b1;
    req_a[32*p +: 32]  = a;
    req_b[32*p +: 32]  = b;
    req_op[4*p +: 4]   = op;
  endtask

  // Called just after a negedge; returns just after the negedge where ready is seen.
  task automatic wait_ready(input int p, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[p]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s ready timeout: got 0 expected 1", name);
    end
  endtask

  task automatic wait_rsp(input int p, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid[p]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s rsp timeout: got 0 expected 1", name);
    end
  endtask

  task automatic finish_rsp(input int p);
    rsp_ready[p] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[p] = 1'b0;
  endtask

  task automatic run_op(input int p, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_err, input string name);
    bit ok;
    drive_req(p, op, a, b);
    wait_ready(p, name, ok);
    check({name, " req_ready"}, 64'(req_ready), 64'(1) << p);
    @(posedge clk);
    @(negedge clk);
    req_valid[p] = 1'b0;
    wait_rsp(p, name, ok);
    check({name, " rsp_valid"}, 64'(rsp_valid), 64'(1) << p);
    check({name, " result"}, 64'(rsp_result), 64'(exp_res));
    check({name, " zero"}, 64'(rsp_zero), 64'(exp_zero));
    check({name, " err"}, 64'(rsp_err), 64'(exp_err));
    finish_rsp(p);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  // ---------------- main sequence ----------------
  initial begin
    bit          ok;
    int          model_ptr;
    int          g;
    bit          pend[NUM_REQ];
    logic [3:0]  pop[NUM_REQ];
    logic [31:0] pa[NUM_REQ];
    logic [31:0] pb[NUM_REQ];
    logic [3:0]  legal_ops[5];
    logic [33:0] r;
    logic [SB_W-1:0] e;
    int          eport;

    vecs[0]  = '{4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1]  = '{4'b0100, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0};
    vecs[2]  = '{4'b1000, 32'd3,        32'd5,        32'd1,        1'b0, 1'b0};
    vecs[3]  = '{4'b1000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[4]  = '{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 32'hF0F01234, 32'hFF00FF00, 32'hF0001200, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 32'h000000F0, 32'h00000F0F, 32'h00000FFF, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[8]  = '{4'b1000, 32'd5,        32'd3,        32'd0,        1'b1, 1'b0};
    vecs[9]  = '{4'b0011, 32'd7,        32'd8,        32'd0,        1'b1, 1'b1};
    vecs[10] = '{4'b0010, 32'd2,        32'd2,        32'd4,        1'b0, 1'b0};
    vecs[11] = '{4'b1111, 32'd6,        32'd6,        32'd0,        1'b1, 1'b1};
    vecs[12] = '{4'b0000, 32'd1,        32'd2,        32'd0,        1'b1, 1'b0};

    legal_ops[0] = 4'b0000;
    legal_ops[1] = 4'b0001;
    legal_ops[2] = 4'b0010;
    legal_ops[3] = 4'b0100;
    legal_ops[4] = 4'b1000;

    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Contention from reset: both hold valid, grants alternate 0,1,0,1.
    drive_req(0, 4'b0010, 32'd1, 32'd2);
    drive_req(1, 4'b0100, 32'd10, 32'd3);
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      #1;
      check($sformatf("contend%0d grant", k), 64'(req_ready), 64'(1) << g);
      @(posedge clk);
      @(negedge clk);
      wait_rsp(g, $sformatf("contend%0d", k), ok);
      check($sformatf("contend%0d rsp_valid", k), 64'(rsp_valid), 64'(1) << g);
      check($sformatf("contend%0d result", k), 64'(rsp_result), (g == 0) ? 64'd3 : 64'd7);
      finish_rsp(g);
    end
    req_valid = '0;

    // Single ADD with cycle-exact timing.
    drive_req(0, 4'b0010, 32'd5, 32'd7);
    #1;
    check("single req_ready", 64'(req_ready), 64'd1);
    check("single idle busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("single exec busy", 64'(busy), 64'd1);
    check("single exec alu_ctrl", 64'(alu_ctrl), 64'h2);
    check("single exec alu_a", 64'(alu_a), 64'd5);
    check("single exec alu_b", 64'(alu_b), 64'd7);
    check("single exec rsp_valid", 64'(rsp_valid), 64'd0);
    check("single exec req_ready", 64'(req_ready), 64'd0);
    req_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("single rsp_valid", 64'(rsp_valid), 64'd1);
    check("single result", 64'(rsp_result), 64'd12);
    check("single zero", 64'(rsp_zero), 64'd0);
    check("single err", 64'(rsp_err), 64'd0);
    finish_rsp(0);
    check("single done rsp_valid", 64'(rsp_valid), 64'd0);
    check("single done busy", 64'(busy), 64'd0);

    for (int i = 0; i < 13; i++) begin
      run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero, vecs[i].err,
             $sformatf("vec%0d", i));
    end

    // Backpressure: owner stalls 5 cycles, pending req1 must wait, stray rsp_ready[1] ignored.
    drive_req(0, 4'b0010, 32'd100, 32'd23);
    wait_ready(0, "bp", ok);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drive_req(1, 4'b0001, 32'h0F, 32'hF0);
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d rsp_valid", c), 64'(rsp_valid), 64'd1);
      check($sformatf("bp%0d result", c), 64'(rsp_result), 64'd123);
      check($sformatf("bp%0d req_ready", c), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready[1] = 1'b0;
    finish_rsp(0);
    run_op(1, 4'b0001, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0, "bp_req1");

    // Reset in the middle of EXEC: no response afterwards, pointer back to 0.
    drive_req(0, 4'b0010, 32'd40, 32'd2);
    wait_ready(0, "rst", ok);
    @(posedge clk);
    @(negedge clk);
    drive_req(1, 4'b0010, 32'd1, 32'd1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("rst_exec");
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rst_after%0d rsp_valid", c), 64'(rsp_valid), 64'd0);
    end
    drive_req(0, 4'b0010, 32'd8, 32'd9);
    drive_req(1, 4'b0100, 32'd8, 32'd9);
    #1;
    check("rst ptr grant", 64'(req_ready), 64'd1);
    req_valid[1] = 1'b0;
    run_op(0, 4'b0010, 32'd8, 32'd9, 32'd17, 1'b0, 1'b0, "rst_op");

    // Randomized traffic; last grant was requester 0 so the pointer now sits at 1.
    model_ptr = 1;
    for (int p = 0; p < NUM_REQ; p++) pend[p] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < NUM_REQ; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          pop[p]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : legal_ops[$urandom_range(0, 4)];
          pa[p]   = $urandom;
          pb[p]   = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
        end
      end
      if (!pend[0] && !pend[1]) begin
        g       = $urandom_range(0, 1);
        pend[g] = 1'b1;
        pop[g]  = legal_ops[$urandom_range(0, 4)];
        pa[g]   = $urandom_range(0, 20);
        pb[g]   = $urandom_range(0, 20);
      end
      for (int p = 0; p < NUM_REQ; p++) begin
        if (pend[p]) drive_req(p, pop[p], pa[p], pb[p]);
      end
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g < 0 && pend[(model_ptr + k) % NUM_REQ]) g = (model_ptr + k) % NUM_REQ;
      end
      #1;
      check($sformatf("rand%0d grant", it), 64'(req_ready), 64'(1) << g);
      r = ref_alu(pop[g], pa[g], pb[g]);
      exp_q.push_back({1'(g), r});
      model_ptr = (g + 1) % NUM_REQ;
      @(posedge clk);
      @(negedge clk);
      pend[g]      = 1'b0;
      req_valid[g] = 1'b0;
      e     = exp_q.pop_front();
      eport = int'(e[34]);
      wait_rsp(eport, $sformatf("rand%0d", it), ok);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("rand%0d rsp_valid", it), 64'(rsp_valid), 64'(1) << eport);
      check($sformatf("rand%0d result", it), 64'(rsp_result), 64'(e[31:0]));
      check($sformatf("rand%0d zero", it), 64'(rsp_zero), 64'(e[32]));
      check($sformatf("rand%0d err", it), 64'(rsp_err), 64'(e[33]));
      finish_rsp(eport);
    end
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
